// File: rtl/tlb_pkg.sv
// rtl/tlb_pkg.sv - shared types for the TLB lookup/flush arbiter
package tlb_pkg;

    localparam int unsigned ASID_WIDTH = 9;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        LOOKUP,
        RESP
    } arb_state_e;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_e;

endpackage

// File: rtl/tlb_lookup_arbiter_if.sv
// rtl/tlb_lookup_arbiter_if.sv - lookup/flush port between the arbiter and the sv32 TLB
interface tlb_lookup_arbiter_if #(
    parameter int unsigned VLEN       = 32,
    parameter int unsigned ASID_WIDTH = 9,
    parameter int unsigned PTE_WIDTH  = 32
);
    logic                  tlb_flush_o;
    logic [ASID_WIDTH-1:0] tlb_asid_flush_o;
    logic [VLEN-1:0]       tlb_vaddr_flush_o;
    logic                  tlb_lu_access_o;
    logic [ASID_WIDTH-1:0] tlb_lu_asid_o;
    logic [VLEN-1:0]       tlb_lu_vaddr_o;
    logic                  tlb_lu_hit_i;
    logic [PTE_WIDTH-1:0]  tlb_lu_content_i;
    logic                  tlb_lu_is_4M_i;

    modport master (
        output tlb_flush_o, tlb_asid_flush_o, tlb_vaddr_flush_o,
        output tlb_lu_access_o, tlb_lu_asid_o, tlb_lu_vaddr_o,
        input  tlb_lu_hit_i, tlb_lu_content_i, tlb_lu_is_4M_i
    );

    modport slave (
        input  tlb_flush_o, tlb_asid_flush_o, tlb_vaddr_flush_o,
        input  tlb_lu_access_o, tlb_lu_asid_o, tlb_lu_vaddr_o,
        output tlb_lu_hit_i, tlb_lu_content_i, tlb_lu_is_4M_i
    );
endinterface

// File: rtl/tlb_lookup_arbiter_rr_arb2.sv
// rtl/tlb_lookup_arbiter_rr_arb2.sv - two-way round-robin grant with last-grant register
import tlb_pkg::*;

module rr_arb2 (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   i_valid_i,
    input  logic   d_valid_i,
    input  logic   accept_i,
    output owner_e grant_o
);
    owner_e last_grant_q;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        grant_o = OWN_I;
        if (i_valid_i && d_valid_i) begin
            grant_o = (last_grant_q == OWN_D) ? OWN_I : OWN_D;
        end else if (d_valid_i) begin
            grant_o = OWN_D;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_q <= OWN_D;
        end else if (accept_i) begin
            last_grant_q <= grant_o;
        end
    end
endmodule

// File: rtl/tlb_lookup_arbiter.sv
// rtl/tlb_lookup_arbiter.sv - shares the TLB lookup/flush port between I and D requesters
import tlb_pkg::*;

module tlb_lookup_arbiter #(
    parameter int unsigned VLEN       = 32,
    parameter int unsigned ASID_WIDTH = tlb_pkg::ASID_WIDTH,
    parameter int unsigned PTE_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_req_i,
    input  logic [ASID_WIDTH-1:0] flush_asid_i,
    input  logic [VLEN-1:0]       flush_vaddr_i,
    output logic                  flush_ack_o,
    input  logic                  i_req_valid_i,
    input  logic                  d_req_valid_i,
    output logic                  i_req_ready_o,
    output logic                  d_req_ready_o,
    input  logic [VLEN-1:0]       i_vaddr_i,
    input  logic [VLEN-1:0]       d_vaddr_i,
    input  logic [ASID_WIDTH-1:0] i_asid_i,
    input  logic [ASID_WIDTH-1:0] d_asid_i,
    output logic                  i_rsp_valid_o,
    output logic                  d_rsp_valid_o,
    output logic                  rsp_hit_o,
    output logic [PTE_WIDTH-1:0]  rsp_content_o,
    output logic                  rsp_is_4M_o,
    tlb_lookup_arbiter_if.master  tlb
);
    arb_state_e            state_q;
    owner_e                owner_q;
    owner_e                grant;
    logic                  handshake;
    logic                  flush_q;
    logic                  flush_ack_q;
    logic [ASID_WIDTH-1:0] asid_flush_q;
    logic [VLEN-1:0]       vaddr_flush_q;
    logic                  lu_access_q;
    logic [ASID_WIDTH-1:0] lu_asid_q;
    logic [VLEN-1:0]       lu_vaddr_q;
    logic                  i_rsp_q;
    logic                  d_rsp_q;
    logic                  hit_q;
    logic [PTE_WIDTH-1:0]  content_q;
    logic                  is_4m_q;
    logic                  can_grant;

    rr_arb2 u_rr_arb2 (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_valid_i (i_req_valid_i),
        .d_valid_i (d_req_valid_i),
        .accept_i  (handshake),
        .grant_o   (grant)
    );

    // A pending flush blocks new grants so it cannot be starved by lookups.
    assign can_grant     = !rst_i && (state_q == IDLE) && !flush_req_i;
    assign i_req_ready_o = can_grant && i_req_valid_i && (grant == OWN_I);
    assign d_req_ready_o = can_grant && d_req_valid_i && (grant == OWN_D);
    assign handshake     = i_req_ready_o || d_req_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            owner_q       <= OWN_I;
            flush_q       <= 1'b0;
            flush_ack_q   <= 1'b0;
            asid_flush_q  <= '0;
            vaddr_flush_q <= '0;
            lu_access_q   <= 1'b0;
            lu_asid_q     <= '0;
            lu_vaddr_q    <= '0;
            i_rsp_q       <= 1'b0;
            d_rsp_q       <= 1'b0;
            hit_q         <= 1'b0;
            content_q     <= '0;
            is_4m_q       <= 1'b0;
        end else begin
            flush_q       <= 1'b0;
            flush_ack_q   <= 1'b0;
            asid_flush_q  <= '0;
            vaddr_flush_q <= '0;
            lu_access_q   <= 1'b0;
            lu_asid_q     <= '0;
            lu_vaddr_q    <= '0;
            i_rsp_q       <= 1'b0;
            d_rsp_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (flush_req_i) begin
                        state_q       <= FLUSH;
                        flush_q       <= 1'b1;
                        flush_ack_q   <= 1'b1;
                        asid_flush_q  <= flush_asid_i;
                        vaddr_flush_q <= flush_vaddr_i;
                    end else if (handshake) begin
                        // The lookup output registers double as the request capture.
                        state_q     <= LOOKUP;
                        owner_q     <= grant;
                        lu_access_q <= 1'b1;
                        lu_asid_q   <= (grant == OWN_I) ? i_asid_i : d_asid_i;
                        lu_vaddr_q  <= (grant == OWN_I) ? i_vaddr_i : d_vaddr_i;
                    end
                end
                FLUSH: begin
                    state_q <= IDLE;
                end
                LOOKUP: begin
                    state_q   <= RESP;
                    hit_q     <= tlb.tlb_lu_hit_i;
                    content_q <= tlb.tlb_lu_content_i;
                    is_4m_q   <= tlb.tlb_lu_is_4M_i;
                    i_rsp_q   <= (owner_q == OWN_I);
                    d_rsp_q   <= (owner_q == OWN_D);
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign flush_ack_o           = flush_ack_q;
    assign i_rsp_valid_o         = i_rsp_q;
    assign d_rsp_valid_o         = d_rsp_q;
    assign rsp_hit_o             = hit_q;
    assign rsp_content_o         = content_q;
    assign rsp_is_4M_o           = is_4m_q;
    assign tlb.tlb_flush_o       = flush_q;
    assign tlb.tlb_asid_flush_o  = asid_flush_q;
    assign tlb.tlb_vaddr_flush_o = vaddr_flush_q;
    assign tlb.tlb_lu_access_o   = lu_access_q;
    assign tlb.tlb_lu_asid_o     = lu_asid_q;
    assign tlb.tlb_lu_vaddr_o    = lu_vaddr_q;
endmodule

// File: doc/tlb_lookup_arbiter.md
Name: tlb_lookup_arbiter

Overview:
- Shares the single sv32 TLB lookup/flush port between the instruction requester (I) and data requester (D).
- Also sequences SFENCE-driven flushes into the TLB.
- Registers each granted lookup, drives the TLB lookup port for one cycle, and returns the registered hit/PTE result to the owner.
- Sits between the MMU front end and the tlb instance.

Parameters:
- VLEN, 32, virtual address width.
- ASID_WIDTH, 9, ASID width.
- PTE_WIDTH, 32, width of riscv::pte_sv32_t.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_req_i  in  1  flush request, level, held until ack
- flush_asid_i  in  ASID_WIDTH  ASID to flush
- flush_vaddr_i  in  VLEN  vaddr to flush
- flush_ack_o  out  1  one-cycle flush-done pulse
- i_req_valid_i / d_req_valid_i  in  1  lookup request
- i_req_ready_o / d_req_ready_o  out  1  request accepted
- i_vaddr_i / d_vaddr_i  in  VLEN  lookup vaddr
- i_asid_i / d_asid_i  in  ASID_WIDTH  lookup ASID
- i_rsp_valid_o / d_rsp_valid_o  out  1  one-cycle result pulse
- rsp_hit_o  out  1  shared result: hit
- rsp_content_o  out  PTE_WIDTH  shared result: PTE
- rsp_is_4M_o  out  1  shared result: superpage
- tlb_flush_o  out  1  to TLB flush_i
- tlb_asid_flush_o  out  ASID_WIDTH  to TLB asid_to_be_flushed_i
- tlb_vaddr_flush_o  out  VLEN  to TLB vaddr_to_be_flushed_i
- tlb_lu_access_o  out  1  to TLB lu_access_i
- tlb_lu_asid_o  out  ASID_WIDTH  to TLB lu_asid_i
- tlb_lu_vaddr_o  out  VLEN  to TLB lu_vaddr_i
- tlb_lu_hit_i  in  1  from TLB (combinational, same cycle)
- tlb_lu_content_i  in  PTE_WIDTH  from TLB
- tlb_lu_is_4M_i  in  1  from TLB

Behaviour:

FSM states: IDLE, FLUSH, LOOKUP, RESP.

IDLE
- If flush_req_i is high, go to FLUSH. Both ready outputs are 0.
- Otherwise grant one valid requester:
  - Round-robin: the requester not in last_grant_q wins a tie.
  - A single valid requester wins outright.
- Granted ready_o is combinational (valid & grant & !flush_req_i); the other ready_o is 0.
- On handshake:
  - Capture vaddr/asid/owner into registers.
  - Update last_grant_q.
  - Go to LOOKUP.

FLUSH (exactly 1 cycle)
- tlb_flush_o=1 and flush_ack_o=1.
- tlb_asid_flush_o / tlb_vaddr_flush_o driven from flush_asid_i / flush_vaddr_i.
- Next state is IDLE.
- Requester drops flush_req_i the cycle after ack.

LOOKUP (1 cycle)
- tlb_lu_access_o=1 with the captured asid/vaddr.
- Register tlb_lu_hit_i, tlb_lu_content_i and tlb_lu_is_4M_i at the clock edge.
- Next state is RESP.

RESP (1 cycle)
- Owner's rsp_valid_o=1; rsp_* hold the registered result.
- Next state is IDLE.

Latency and throughput
- Handshake in cycle N, TLB access in N+1, rsp_valid in N+2.
- At most one lookup every 3 cycles.

Flush arbitration
- A flush has priority over lookups in IDLE.
- A flush raised during LOOKUP/RESP waits; the in-flight lookup completes first.

Output rules
- tlb_lu_* address/asid outputs are 0 when not in LOOKUP.
- tlb_*_flush_o data outputs are 0 when not in FLUSH.

Reset (rst_i)
- state=IDLE, last_grant_q=D (so I wins the first tie).
- All outputs 0; result regs 0.
- An in-flight lookup is dropped with no rsp_valid.
- Reset has priority over all events.

Decomposition:
- Shared package (tlb_pkg): ASID_WIDTH, the arb_state_e enum (IDLE/FLUSH/LOOKUP/RESP), and the owner_e enum (OWN_I/OWN_D).
- Reuse riscv::pte_sv32_t for content.
- One sub-module, rr_arb2 (2-way round-robin grant with last-grant register), is natural.

Test Plan:
- Reset, then only I valid, vaddr=0x8000_1000, asid=3, TLB hit content=0x2000_00CF:
  - i_req_ready_o=1 in cycle 0.
  - tlb_lu_access_o=1 with those values in cycle 1.
  - i_rsp_valid_o=1, rsp_hit_o=1, rsp_content_o=0x2000_00CF in cycle 2.
  - d_rsp_valid_o=0 throughout.
- I and D both valid continuously for 4 grants: grant order I,D,I,D; rsp pulses at cycles 2,5,8,11.
- flush_req_i and both valids high in the same IDLE cycle, asid=5, vaddr=0x0040_0000:
  - FLUSH next cycle with tlb_flush_o=1, flush_ack_o=1, tlb_asid_flush_o=5.
  - No ready asserted until after the ack.
- D granted, flush_req_i raised during LOOKUP: d_rsp_valid_o pulses first, then tlb_flush_o in the following IDLE→FLUSH sequence.
- TLB miss (tlb_lu_hit_i=0) on a D lookup: d_rsp_valid_o=1, rsp_hit_o=0.
- rst_i asserted in LOOKUP: next cycle all outputs 0, no rsp_valid; the next I/D tie is granted to I.
